// File: rtl/datapath_pipe.sv
`default_nettype none
// datapath_pipe: two-stage EX/WB datapath with register file, function unit, status flags. Rev 1.0
// Build macro DATAPATH_FWD_EN: WB->EX forwarding; undefined, RAW hazards stall one cycle.
module datapath_pipe #(
  parameter int WIDTH = 4,
  parameter int NREGS = 4
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       cw_valid,
  output logic                       cw_ready,
  input  logic [3*$clog2(NREGS)+6:0] ControlWord,
  input  logic [WIDTH-1:0]           ConstantIn,
  input  logic [WIDTH-1:0]           DataIn,
  output logic [WIDTH-1:0]           AddressOut,
  output logic [WIDTH-1:0]           DataOut,
  output logic [3:0]                 Flags,
  output logic [NREGS*WIDTH-1:0]     RegsOut
);
  localparam int AW = $clog2(NREGS);

  logic [AW-1:0]    da, aa, ba;
  logic             mb, md, rw;
  logic [3:0]       fs;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic             wb_valid_q, wb_rw_q;
  logic [AW-1:0]    wb_da_q;
  logic [WIDTH-1:0] wb_data_q, wb_data_d;
  logic [3:0]       flags_q, flags_d;
  logic             hazard_a, hazard_b, accept;
  logic [WIDTH-1:0] a_op, b_reg, b_op;
  logic [WIDTH-1:0] y_arith, f_res;
  logic [WIDTH:0]   sum;
  logic             cin, c_flag, v_flag;

  assign rw = ControlWord[0];
  assign md = ControlWord[1];
  assign fs = ControlWord[5:2];
  assign mb = ControlWord[6];
  assign ba = ControlWord[7 +: AW];
  assign aa = ControlWord[7+AW +: AW];
  assign da = ControlWord[7+2*AW +: AW];

  assign hazard_a = wb_valid_q && wb_rw_q && (wb_da_q == aa);
  assign hazard_b = wb_valid_q && wb_rw_q && (wb_da_q == ba);

`ifdef DATAPATH_FWD_EN
  assign a_op     = hazard_a ? wb_data_q : regs_q[aa];
  assign b_reg    = hazard_b ? wb_data_q : regs_q[ba];
  assign cw_ready = 1'b1;
`else
  assign a_op     = regs_q[aa];
  assign b_reg    = regs_q[ba];
  // B only matters when the operand mux picks the register
  assign cw_ready = !(hazard_a || (!mb && hazard_b));
`endif

  assign b_op   = mb ? ConstantIn : b_reg;
  assign accept = cw_valid && cw_ready;

  always_comb begin
    y_arith = '0;
    cin     = 1'b0;
    sum     = '0;
    f_res   = '0;
    c_flag  = 1'b0;
    v_flag  = 1'b0;
    case (fs[2:0])
      3'b001:  cin = 1'b1;
      3'b010:  y_arith = b_op;
      3'b011:  begin y_arith = b_op; cin = 1'b1; end
      3'b100:  y_arith = ~b_op;
      3'b101:  begin y_arith = ~b_op; cin = 1'b1; end
      3'b110:  y_arith = '1;
      default: y_arith = '0;
    endcase
    if (!fs[3]) begin
      // every arithmetic code is A + Y + cin, so carry and overflow share one adder
      sum    = {1'b0, a_op} + {1'b0, y_arith} + {{WIDTH{1'b0}}, cin};
      f_res  = sum[WIDTH-1:0];
      c_flag = sum[WIDTH];
      v_flag = (a_op[WIDTH-1] == y_arith[WIDTH-1]) && (f_res[WIDTH-1] != a_op[WIDTH-1]);
    end else begin
      case (fs[2:0])
        3'b000:  f_res = a_op & b_op;
        3'b001:  f_res = a_op | b_op;
        3'b010:  f_res = a_op ^ b_op;
        3'b011:  f_res = ~a_op;
        3'b100:  f_res = b_op;
        3'b101:  begin f_res = {1'b0, b_op[WIDTH-1:1]}; c_flag = b_op[0]; end
        3'b110:  begin f_res = {b_op[WIDTH-2:0], 1'b0}; c_flag = b_op[WIDTH-1]; end
        default: f_res = '0;
      endcase
    end
  end

  assign flags_d   = {v_flag, c_flag, f_res[WIDTH-1], (f_res == '0)};
  assign wb_data_d = md ? DataIn : f_res;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      wb_valid_q <= 1'b0;
      wb_rw_q    <= 1'b0;
      wb_da_q    <= '0;
      wb_data_q  <= '0;
      flags_q    <= '0;
    end else begin
      if (wb_valid_q && wb_rw_q) regs_q[wb_da_q] <= wb_data_q;
      wb_valid_q <= accept;
      if (accept) begin
        wb_rw_q   <= rw;
        wb_da_q   <= da;
        wb_data_q <= wb_data_d;
        flags_q   <= flags_d;
      end
    end
  end

  assign AddressOut = a_op;
  assign DataOut    = b_op;
  assign Flags      = flags_q;

  for (genvar g = 0; g < NREGS; g++) begin : g_regs_out
    assign RegsOut[g*WIDTH +: WIDTH] = regs_q[g];
  end
endmodule
`default_nettype wire

// File: tb/tb_datapath_pipe.sv
`default_nettype none
// tb_datapath_pipe: scoreboard bench for a 4-bit/4-reg and an 8-bit/8-reg datapath_pipe.
module tb_datapath_pipe;
  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        cv4 = 1'b0, cv8 = 1'b0, rdy4, rdy8;
  logic [12:0] cw4 = '0;
  logic [15:0] cw8 = '0;
  logic [3:0]  k4 = '0, din4 = '0, ao4, do4, fl4, fl8;
  logic [7:0]  k8 = '0, din8 = '0, ao8, do8;
  logic [15:0] ro4;
  logic [63:0] ro8;
  int          cyc = 0;
  int          n_total = 0;
  int          n_bad = 0;

  typedef struct {int due; int sel; int kind; int idx; logic [7:0] val;} ent_t;
  ent_t        sbq[$];
  logic [7:0]  m[2][8];

  datapath_pipe #(.WIDTH(4), .NREGS(4)) u_dut4 (
    .CLK(CLK), .nRST(nRST), .cw_valid(cv4), .cw_ready(rdy4), .ControlWord(cw4),
    .ConstantIn(k4), .DataIn(din4), .AddressOut(ao4), .DataOut(do4), .Flags(fl4), .RegsOut(ro4));
  datapath_pipe #(.WIDTH(8), .NREGS(8)) u_dut8 (
    .CLK(CLK), .nRST(nRST), .cw_valid(cv8), .cw_ready(rdy8), .ControlWord(cw8),
    .ConstantIn(k8), .DataIn(din8), .AddressOut(ao8), .DataOut(do8), .Flags(fl8), .RegsOut(ro8));

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic ref_alu(input int w, input int fs, input longint a, input longint b,
                         output longint f, output logic [3:0] fl);
    longint mask, half, y, cin, full, sa, sy, sres;
    logic c, v;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    c = 1'b0; v = 1'b0; f = 0; y = 0; cin = 0;
    if (fs < 8) begin
      case (fs)
        1: cin = 1;
        2: y = b;
        3: begin y = b; cin = 1; end
        4: y = mask - b;
        5: begin y = mask - b; cin = 1; end
        6: y = mask;
        default: y = 0;
      endcase
      full = a + y + cin;
      c = (full > mask);
      sa = (a >= half) ? a - (mask + 1) : a;
      sy = (y >= half) ? y - (mask + 1) : y;
      sres = sa + sy + cin;
      v = (sres >= half) || (sres < -half);
      f = full & mask;
    end else begin
      case (fs)
        8:  f = a & b;
        9:  f = a | b;
        10: f = a ^ b;
        11: f = mask - a;
        12: f = b;
        13: begin f = b >> 1; c = b[0]; end
        14: begin f = (b << 1) & mask; c = ((b >> (w - 1)) & 1) != 0; end
        default: f = 0;
      endcase
    end
    fl = {v, c, ((f >> (w - 1)) & 1) != 0, f == 0};
  endtask

  task automatic check_due();
    ent_t e;
    logic [7:0] obs;
    string nm;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      if (e.kind == 0) begin
        nm  = "flags";
        obs = (e.sel != 0) ? {4'b0, fl8} : {4'b0, fl4};
      end else begin
        nm  = "reg";
        obs = (e.sel != 0) ? ro8[e.idx*8 +: 8] : {4'b0, ro4[e.idx*4 +: 4]};
      end
      n_total++;
      if (e.due != cyc || obs !== e.val) begin
        n_bad++;
        $display("FAIL %s dut=%0d idx=%0d got=%h exp=%h due=%0d cyc=%0d",
                 nm, e.sel, e.idx, obs, e.val, e.due, cyc);
      end
    end
  endtask

  task automatic idle(input int n);
    cv4 = 1'b0; cv8 = 1'b0;
    repeat (n) begin @(negedge CLK); check_due(); @(posedge CLK); #1; end
  endtask

  task automatic issue(input int sel, input int da, input int aa, input int ba, input int mb,
                       input int fs, input int md, input int rw, input logic [7:0] k,
                       input logic [7:0] din, output int stalls);
    int w, aw, cwv;
    longint av, bv, fv, dv, mask;
    logic [3:0] fl;
    logic rdy;
    logic [7:0] ao, dout;
    w = (sel != 0) ? 8 : 4;
    aw = (sel != 0) ? 3 : 2;
    mask = (longint'(1) << w) - 1;
    cwv = (da << (7 + 2*aw)) | (aa << (7 + aw)) | (ba << 7) | (mb << 6) | (fs << 2) | (md << 1) | rw;
    av = longint'(m[sel][aa]);
    bv = (mb != 0) ? (longint'(k) & mask) : longint'(m[sel][ba]);
    ref_alu(w, fs, av, bv, fv, fl);
    dv = (md != 0) ? (longint'(din) & mask) : fv;
    if (sel == 0) begin cw4 = cwv[12:0]; k4 = k[3:0]; din4 = din[3:0]; cv4 = 1'b1; end
    else begin cw8 = cwv[15:0]; k8 = k; din8 = din; cv8 = 1'b1; end
    stalls = 0;
    @(negedge CLK); check_due();
    rdy = (sel != 0) ? rdy8 : rdy4;
    while (!rdy && stalls < 4) begin
      stalls++;
      @(posedge CLK); #1;
      @(negedge CLK); check_due();
      rdy = (sel != 0) ? rdy8 : rdy4;
    end
    n_total++;
    if (!rdy) begin
      n_bad++;
      $display("FAIL ready_timeout dut=%0d got=0 exp=1 after %0d cycles", sel, stalls);
      cv4 = 1'b0; cv8 = 1'b0;
      @(posedge CLK); #1;
      return;
    end
    ao   = (sel != 0) ? ao8 : {4'b0, ao4};
    dout = (sel != 0) ? do8 : {4'b0, do4};
    n_total += 2;
    if (ao !== av[7:0]) begin
      n_bad++; $display("FAIL AddressOut dut=%0d got=%h exp=%h", sel, ao, av[7:0]);
    end
    if (dout !== bv[7:0]) begin
      n_bad++; $display("FAIL DataOut dut=%0d got=%h exp=%h", sel, dout, bv[7:0]);
    end
    if (rw != 0) m[sel][da] = dv[7:0];
    sbq.push_back('{due: cyc + 1, sel: sel, kind: 0, idx: 0, val: {4'b0, fl}});
    if (rw != 0) sbq.push_back('{due: cyc + 2, sel: sel, kind: 1, idx: da, val: dv[7:0]});
    @(posedge CLK); #1;
    cv4 = 1'b0; cv8 = 1'b0;
  endtask

  task automatic clear_model();
    for (int s = 0; s < 2; s++) for (int i = 0; i < 8; i++) m[s][i] = 8'h00;
  endtask

  task automatic test_reset();
    int st;
    issue(0, 1, 0, 0, 1, 12, 0, 1, 8'h5, 8'h0, st);
    issue(0, 2, 0, 0, 1, 12, 0, 1, 8'h3, 8'h0, st);
    @(negedge CLK); check_due();
    // R2 is still sitting in WB here; reset must discard it
    nRST = 1'b0;
    sbq.delete();
    clear_model();
    @(posedge CLK); @(posedge CLK); #1;
    @(negedge CLK);
    n_total += 4;
    if (ro4 !== 16'h0) begin n_bad++; $display("FAIL reset_regs4 got=%h exp=0000", ro4); end
    if (ro8 !== 64'h0) begin n_bad++; $display("FAIL reset_regs8 got=%h exp=0", ro8); end
    if (fl4 !== 4'h0)  begin n_bad++; $display("FAIL reset_flags got=%h exp=0", fl4); end
    if (rdy4 !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", rdy4); end
    nRST = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_imm();
    int st;
    issue(0, 1, 0, 0, 1, 12, 0, 1, 8'h7, 8'h0, st);
    issue(0, 2, 0, 0, 1, 12, 0, 1, 8'h9, 8'h0, st);
    idle(3);
  endtask

  task automatic test_back_to_back();
    int st, exp_st;
`ifdef DATAPATH_FWD_EN
    exp_st = 0;
`else
    exp_st = 1;
`endif
    issue(0, 1, 1, 2, 0, 2, 0, 1, 8'h0, 8'h0, st);
    issue(0, 3, 1, 0, 0, 1, 0, 1, 8'h0, 8'h0, st);
    n_total++;
    if (st != exp_st) begin n_bad++; $display("FAIL b2b_stalls got=%0d exp=%0d", st, exp_st); end
    idle(3);
  endtask

  task automatic test_ovf_shift();
    int st;
    issue(0, 1, 0, 0, 1, 12, 0, 1, 8'h7, 8'h0, st);
    issue(0, 2, 1, 0, 0, 1, 0, 1, 8'h0, 8'h0, st);
    issue(0, 3, 0, 0, 1, 14, 0, 1, 8'h8, 8'h0, st);
    issue(0, 0, 2, 0, 1, 13, 0, 1, 8'h3, 8'h0, st);
    idle(3);
  endtask

  task automatic test_mem();
    int st;
    issue(0, 3, 0, 0, 1, 12, 0, 1, 8'h5, 8'h0, st);
    issue(0, 0, 3, 0, 0, 0, 1, 1, 8'h0, 8'hA, st);
    idle(3);
  endtask

  task automatic test_sweep();
    int st, ra, rb;
    for (int fs = 0; fs < 16; fs++) begin
      for (int r = 0; r < 3; r++) begin
        ra = $urandom_range(7);
        rb = $urandom_range(7);
        issue(1, ra, 0, 0, 1, 12, 0, 1, 8'($urandom), 8'h0, st);
        issue(1, rb, 0, 0, 1, 12, 0, 1, 8'($urandom), 8'h0, st);
        issue(1, $urandom_range(7), ra, rb, $urandom_range(1), fs,
              ($urandom_range(3) == 0) ? 1 : 0, 1, 8'($urandom), 8'($urandom), st);
      end
    end
    idle(4);
  endtask

  initial begin
    clear_model();
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    test_reset();
    test_imm();
    test_back_to_back();
    test_ovf_shift();
    test_mem();
    test_sweep();
    n_total++;
    if (sbq.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_drain got=%0d exp=0 entries", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
